frequency_shift_transmitter: RTL and testbench
==============================================

Name: frequency_shift_transmitter

Overview:
- Optical FSK modulator; the transmit end of the link whose receive end is the per-pixel frequency_analyzer (F1/F2 tone detection on a sampled pixel bit).
- Accepts a DATA_WIDTH word via valid/ready and drives a light source (LED/laser enable) with one tone symbol per bit:
  - bit 0 -> square wave at FREQUENCY_1
  - bit 1 -> square wave at FREQUENCY_2
- Used for in-field calibration of the frequency analyzer and for camera-to-beacon signalling.

Parameters:
- FREQUENCY_1, 9000, tone frequency in Hz for a 0 bit.
- FREQUENCY_2, 11000, tone frequency in Hz for a 1 bit.
- CLOCK, 100000000, clock frequency in Hz.
- SYMBOL_CYCLES, 1000000, clocks per tone symbol; must be >= 2.
- GAP_CYCLES, 100000, clocks of dark output after each symbol; 0 means no gap.
- DATA_WIDTH, 8, bits per frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permits frame acceptance.
- tx_data  in  DATA_WIDTH  frame payload; transmitted LSB first.
- tx_valid  in  1  payload valid.
- tx_ready  out  1  block can accept a frame.
- light_out  out  1  modulated light drive.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: all outputs 0 (tx_ready, light_out, busy, done); state IDLE; all counters 0. Reset asserted mid-frame aborts on the next edge and drops light_out to 0 immediately.
- Derived constants (integer division, truncating):
  - HALF_1 = CLOCK/(2*FREQUENCY_1)
  - HALF_2 = CLOCK/(2*FREQUENCY_2)
  - Both must be >= 1; a compile-time check fails otherwise.
- Counter widths are $clog2 of their maximum value + 1.
- State IDLE: tx_ready = enable; light_out = 0; busy = 0.
  - On tx_valid & tx_ready: latch tx_data into the shift register, bit_index = 0, then go to TONE.
  - tx_data is sampled only on the accept edge.
- State TONE:
  - busy = 1, tx_ready = 0.
  - light_out is 1 on the first cycle of every symbol, i.e. phase resets per symbol.
  - light_out toggles after every HALF_x clocks, with x selected by the current LSB of the shift register.
  - Symbol counter runs 0..SYMBOL_CYCLES-1. At SYMBOL_CYCLES-1, go to GAP, or to NEXT when GAP_CYCLES == 0.
  - A partial final half-period is truncated at the symbol boundary.
- State GAP: light_out = 0 for exactly GAP_CYCLES clocks, then NEXT.
- NEXT (a decision, not a state: no extra cycle):
  - If bit_index == DATA_WIDTH-1: go to IDLE and pulse done on the first IDLE cycle.
  - Otherwise: shift right, increment bit_index, and enter TONE.
- Frame latency: accept edge to done = DATA_WIDTH*(SYMBOL_CYCLES+GAP_CYCLES) clocks.
- Back-to-back frames: tx_ready may be high in the done cycle (same cycle). Minimum one IDLE cycle between frames.
- enable deasserted mid-frame: the current frame completes and only new acceptance is blocked.
- tx_valid held while busy: ignored; the data is not consumed.

Optional Feature:
- Macro FSK_PREAMBLE_EN.
- Defined: each frame is prefixed with two preamble symbols, one F2 tone then one F1 tone, each followed by its gap. This gives the receiver a reference for both tones. Frame latency grows by 2*(SYMBOL_CYCLES+GAP_CYCLES).
- Undefined: data symbols start immediately after acceptance, with no preamble logic synthesized.

Decomposition:
- Package freq_tx_pkg holds:
  - state enum (IDLE, PREAMBLE when FSK_PREAMBLE_EN is defined, TONE, GAP)
  - half-period function of (CLOCK, frequency)
  - constant counter-width helper
- One sub-module, fsk_tone_generator:
  - inputs: clock, reset, restart, select, run
  - output: square
  - contains the half-period counter and toggle flop; restart forces square = 1 and counter = 0.

Test Plan (bench params CLOCK=1000, FREQUENCY_1=100 -> HALF=5, FREQUENCY_2=125 -> HALF=4, SYMBOL_CYCLES=40, GAP_CYCLES=10, DATA_WIDTH=8):
- Send 0xA5 -> symbols 1,0,1,0,0,1,0,1; per-symbol rising edges on light_out 5,4,5,4,4,5,4,5; light_out = 0 for 10 cycles after each symbol; done exactly 400 clocks after the accept edge; busy = 1 throughout.
- Set GAP_CYCLES=0 and send 0x00 -> 8 contiguous F1 symbols, 32 rising edges in total, done at clock 320.
- Assert reset at clock 137 of a frame -> light_out, busy, tx_ready are 0 next cycle; no done pulse; next frame is accepted normally.
- Hold tx_valid with 0x01 then 0xFF back-to-back -> second frame is accepted in the done cycle; total of 801 clocks from first accept to second done.
- Drop enable at clock 50 of a frame -> frame completes with done at 400; tx_ready stays 0 afterwards until enable returns.
- With FSK_PREAMBLE_EN, send 0x0F -> 5 then 4 rising edges in the preamble precede the data; done at clock 500.

Source files
------------

// File: rtl/freq_tx_pkg.sv
// freq_tx_pkg: shared FSK transmitter types and helpers; FSK_PREAMBLE_EN adds the PREAMBLE state
package freq_tx_pkg;
  typedef enum logic [1:0] {
    IDLE,
`ifdef FSK_PREAMBLE_EN
    PREAMBLE,
`endif
    TONE,
    GAP
  } state_t;
  function automatic int half_period(input int clock_hz, input int freq_hz);
    return clock_hz / (2 * freq_hz);
  endfunction
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction
endpackage

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator: square wave at one of two half-periods, phase reset by restart
module fsk_tone_generator import freq_tx_pkg::*; #(
  parameter int HALF_1 = 5,
  parameter int HALF_2 = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic select,
  input  logic run,
  output logic square
);
  localparam int HW = cnt_width((HALF_1 > HALF_2 ? HALF_1 : HALF_2) - 1);
  logic [HW-1:0] cnt_q, cnt_d, last;
  logic square_q, square_d;
  assign last = select ? HW'(HALF_2 - 1) : HW'(HALF_1 - 1);
  // half-period counter; toggle on wrap, restart starts a fresh high phase
  always_comb begin
    cnt_d = restart ? '0 : !run ? cnt_q : (cnt_q == last) ? '0 : cnt_q + 1'b1;
    square_d = restart ? 1'b1 : (run && cnt_q == last) ? ~square_q : square_q;
  end
  // tone state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      square_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      square_q <= square_d;
    end
  end
  assign square = square_q;
endmodule

// File: rtl/frequency_shift_transmitter.sv
// frequency_shift_transmitter: optical FSK modulator, one tone symbol per bit LSB first; FSK_PREAMBLE_EN prefixes an F2,F1 preamble
module frequency_shift_transmitter import freq_tx_pkg::*; #(
  parameter int FREQUENCY_1 = 9000,
  parameter int FREQUENCY_2 = 11000,
  parameter int CLOCK = 100000000,
  parameter int SYMBOL_CYCLES = 1000000,
  parameter int GAP_CYCLES = 100000,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  light_out,
  output logic                  busy,
  output logic                  done
);
  localparam int HALF_1 = half_period(CLOCK, FREQUENCY_1);
  localparam int HALF_2 = half_period(CLOCK, FREQUENCY_2);
  localparam int CW = cnt_width((SYMBOL_CYCLES > GAP_CYCLES ? SYMBOL_CYCLES : GAP_CYCLES) - 1);
  localparam int IW = cnt_width(DATA_WIDTH - 1);
  if (HALF_1 < 1 || HALF_2 < 1) begin : g_half_chk
    $error("tone half-period below one clock");
  end
  if (SYMBOL_CYCLES < 2) begin : g_sym_chk
    $error("SYMBOL_CYCLES must be at least 2");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic done_q, done_d, restart, select, toning, square, sym_end, gap_end, next_sym;
`ifdef FSK_PREAMBLE_EN
  logic [1:0] pre_q, pre_d;
  assign toning = state_q == TONE || state_q == PREAMBLE;
  assign select = (state_q == PREAMBLE) ? (pre_q == 2'd0) : sr_q[0];
`else
  assign toning = state_q == TONE;
  assign select = sr_q[0];
`endif
  assign sym_end = cnt_q == CW'(SYMBOL_CYCLES - 1);
  assign gap_end = cnt_q == CW'(GAP_CYCLES - 1);
  assign next_sym = (toning && sym_end && GAP_CYCLES == 0) || (state_q == GAP && gap_end);
  // frame sequencing: accept, symbol/gap timing and the per-symbol next decision
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sr_d = sr_q;
    done_d = 1'b0;
    restart = 1'b0;
`ifdef FSK_PREAMBLE_EN
    pre_d = pre_q;
`endif
    if (state_q == IDLE) begin
      if (tx_valid && tx_ready) begin
        sr_d = tx_data;
        idx_d = '0;
        cnt_d = '0;
        restart = 1'b1;
`ifdef FSK_PREAMBLE_EN
        pre_d = 2'd0;
        state_d = PREAMBLE;
`else
        state_d = TONE;
`endif
      end
    end else begin
      cnt_d = ((toning && sym_end) || (state_q == GAP && gap_end)) ? '0 : cnt_q + 1'b1;
      if (toning && sym_end && GAP_CYCLES != 0) state_d = GAP;
      if (next_sym) begin
        restart = 1'b1;
`ifdef FSK_PREAMBLE_EN
        if (pre_q != 2'd2) begin
          pre_d = pre_q + 1'b1;
          state_d = (pre_q == 2'd0) ? PREAMBLE : TONE;
        end else
`endif
        if (idx_q == IW'(DATA_WIDTH - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          sr_d = sr_q >> 1;
          idx_d = idx_q + 1'b1;
          state_d = TONE;
        end
      end
    end
  end
  // state and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sr_q <= '0;
      done_q <= 1'b0;
`ifdef FSK_PREAMBLE_EN
      pre_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sr_q <= sr_d;
      done_q <= done_d;
`ifdef FSK_PREAMBLE_EN
      pre_q <= pre_d;
`endif
    end
  end
  fsk_tone_generator #(.HALF_1(HALF_1), .HALF_2(HALF_2)) u_tone (
    .clock(clock),
    .reset(reset),
    .restart(restart),
    .select(select),
    .run(toning),
    .square(square)
  );
  assign tx_ready = state_q == IDLE && enable && !reset;
  assign busy = state_q != IDLE;
  assign light_out = toning && square;
  assign done = done_q;
endmodule

// File: tb/tb_frequency_shift_transmitter.sv
// tb_frequency_shift_transmitter: model-checked bench for two transmitter instances (gap 10 and gap 0)
module tb_frequency_shift_transmitter;
  localparam int CLK = 1000, F1 = 100, F2 = 125, S = 40, DW = 8;
`ifdef FSK_PREAMBLE_EN
  localparam int PRE = 2, LAT8 = 500, LAT0G = 400, EDGES0 = 41, B2B = 1001, B2BACC = 501;
`else
  localparam int PRE = 0, LAT8 = 400, LAT0G = 320, EDGES0 = 32, B2B = 801, B2BACC = 401;
`endif
  logic clk = 0, rst = 1;
  logic en[2], vld[2], tx_ready[2], light[2], busy[2], done[2];
  logic [7:0] dat[2];
  always #5 clk = ~clk;
  frequency_shift_transmitter #(.FREQUENCY_1(F1), .FREQUENCY_2(F2), .CLOCK(CLK), .SYMBOL_CYCLES(S),
    .GAP_CYCLES(10), .DATA_WIDTH(DW)) u0 (.clock(clk), .reset(rst), .enable(en[0]), .tx_data(dat[0]),
    .tx_valid(vld[0]), .tx_ready(tx_ready[0]), .light_out(light[0]), .busy(busy[0]), .done(done[0]));
  frequency_shift_transmitter #(.FREQUENCY_1(F1), .FREQUENCY_2(F2), .CLOCK(CLK), .SYMBOL_CYCLES(S),
    .GAP_CYCLES(0), .DATA_WIDTH(DW)) u1 (.clock(clk), .reset(rst), .enable(en[1]), .tx_data(dat[1]),
    .tx_valid(vld[1]), .tx_ready(tx_ready[1]), .light_out(light[1]), .busy(busy[1]), .done(done[1]));
  int checks = 0, failures = 0, nprint = 0;
  bit act[2], mdone[2];
  int k[2], acc_time[2], done_time[2], lat[2], ndone[2], nacc[2];
  int edges[2][16];
  logic [7:0] md[2];
  logic prev[2];
  int cyc = 0;
  int a5e[8] = '{5, 4, 5, 4, 4, 5, 4, 5};
  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      if (nprint < 40) $display("FAIL %s actual=%0d required=%0d t=%0t", nm, a, e, $time);
      nprint++;
    end
  endtask
  function automatic int gap_of(input int i);
    return (i == 0) ? 10 : 0;
  endfunction
  function automatic int flen(input int i);
    return (PRE + DW) * (S + gap_of(i));
  endfunction
  function automatic int exp_light(input int i, input int kk, input logic [7:0] d);
    int p, sym, off, h;
    logic b;
    p = S + gap_of(i);
    sym = kk / p;
    off = kk % p;
    if (off >= S) return 0;
    b = (sym < PRE) ? (sym == 0) : d[sym - PRE];
    h = CLK / (2 * (b ? F2 : F1));
    return ((off / h) % 2 == 0) ? 1 : 0;
  endfunction
  initial begin
    act = '{0, 0};
    mdone = '{0, 0};
    prev = '{0, 0};
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          act[i] = 0;
          mdone[i] = 0;
        end else if (act[i]) begin
          k[i]++;
          mdone[i] = (k[i] == flen(i));
          if (mdone[i]) act[i] = 0;
        end else begin
          mdone[i] = 0;
          if (vld[i] && en[i]) begin
            act[i] = 1;
            k[i] = 0;
            md[i] = dat[i];
          end
        end
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("light%0d", i), light[i], act[i] ? exp_light(i, k[i], md[i]) : 0);
        chk($sformatf("busy%0d", i), busy[i], act[i]);
        chk($sformatf("ready%0d", i), tx_ready[i], (!act[i] && en[i] && !rst) ? 1 : 0);
        chk($sformatf("done%0d", i), done[i], mdone[i]);
        if (act[i] && k[i] == 0) begin
          acc_time[i] = cyc;
          nacc[i]++;
          for (int s = 0; s < 16; s++) edges[i][s] = 0;
        end
        if (act[i] && light[i] && !prev[i]) edges[i][k[i] / (S + gap_of(i))]++;
        if (done[i]) begin
          done_time[i] = cyc;
          lat[i] = cyc - acc_time[i];
          ndone[i]++;
        end
        prev[i] = light[i];
      end
    end
  end
  task automatic send(input int i, input logic [7:0] d);
    @(negedge clk);
    vld[i] = 1;
    dat[i] = d;
    for (int t = 0; t < 200 && !act[i]; t++) @(negedge clk);
    chk("accept_timeout", act[i], 1);
    vld[i] = 0;
    dat[i] = 8'($urandom);
  endtask
  task automatic wait_done(input int i);
    int n0;
    n0 = ndone[i];
    for (int t = 0; t < 3000 && ndone[i] == n0; t++) @(negedge clk);
    chk("done_timeout", ndone[i] - n0, 1);
  endtask
  initial begin
    int first, n0, tot;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1;
      vld[i] = 0;
      dat[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_light", light[0], 0);
    chk("rst_done", done[0], 0);
    rst = 0;
    fork
      send(0, 8'hA5);
      send(1, 8'h00);
    join
    fork
      wait_done(0);
      wait_done(1);
    join
    for (int j = 0; j < 8; j++) chk($sformatf("a5_edges_sym%0d", j), edges[0][PRE + j], a5e[j]);
    chk("a5_latency", lat[0], LAT8);
`ifdef FSK_PREAMBLE_EN
    chk("pre_f2_edges", edges[0][0], 5);
    chk("pre_f1_edges", edges[0][1], 4);
`endif
    tot = 0;
    for (int j = 0; j < PRE + DW; j++) tot += edges[1][j];
    chk("nogap_edges", tot, EDGES0);
    chk("nogap_latency", lat[1], LAT0G);
    send(0, 8'h3C);
    repeat (136) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #2;
    chk("midrst_light", light[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ready", tx_ready[0], 0);
    @(negedge clk);
    rst = 0;
    n0 = ndone[0];
    repeat (450) @(negedge clk);
    chk("midrst_no_done", ndone[0] - n0, 0);
    send(0, 8'h96);
    wait_done(0);
    chk("after_rst_latency", lat[0], LAT8);
    @(negedge clk);
    vld[0] = 1;
    dat[0] = 8'h01;
    for (int t = 0; t < 50 && !act[0]; t++) @(negedge clk);
    first = acc_time[0];
    n0 = nacc[0];
    dat[0] = 8'hFF;
    for (int t = 0; t < 1200 && nacc[0] == n0; t++) @(negedge clk);
    chk("b2b_second_accept", acc_time[0] - first, B2BACC);
    vld[0] = 0;
    wait_done(0);
    chk("b2b_total", done_time[0] - first, B2B);
    for (int j = 0; j < 8; j++) chk($sformatf("ff_edges_sym%0d", j), edges[0][PRE + j], 5);
    send(0, 8'h5A);
    repeat (49) @(negedge clk);
    en[0] = 0;
    vld[0] = 1;
    dat[0] = 8'hFF;
    wait_done(0);
    chk("endrop_latency", lat[0], LAT8);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("endrop_ready", tx_ready[0], 0);
      chk("endrop_busy", busy[0], 0);
    end
    en[0] = 1;
    for (int t = 0; t < 10 && !act[0]; t++) @(negedge clk);
    chk("enable_return_accept", act[0], 1);
    vld[0] = 0;
    wait_done(0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        en[i] = ($urandom_range(0, 7) != 0);
        vld[i] = ($urandom_range(0, 3) == 0);
        dat[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 0;
    vld[0] = 0;
    vld[1] = 0;
    repeat (600) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
